// File: rtl/mem_arbiter.sv
// Byte-serial arbiter sharing one 8-bit RAM port between instruction fetch and load/store.
// Optional round-robin grant between the two requesters is enabled by defining MEM_ARB_RR_EN.
module mem_arbiter #(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [31:0]       if_data,
    output logic              if_done,
    input  logic              mem_req,
    input  logic              mem_we,
    input  logic [2:0]        mem_len,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [31:0]       mem_wdata,
    output logic [31:0]       mem_rdata,
    output logic              mem_done,
    output logic [ADDR_W-1:0] ram_a,
    output logic [7:0]        ram_dout,
    output logic              ram_wr,
    input  logic [7:0]        ram_din,
    output logic              stallreq_if,
    output logic              stallreq_mem
);

    typedef enum logic [1:0] {ST_IDLE, ST_BUSY_IF, ST_BUSY_MEM} state_t;

    state_t            r_state;
    state_t            w_state_next;
    logic [ADDR_W-1:0] r_addr;
    logic [ADDR_W-1:0] r_ram_a;
    logic [31:0]       r_wdata;
    logic [31:0]       r_buf;
    logic [31:0]       r_if_data;
    logic [31:0]       r_mem_rdata;
    logic [7:0]        r_ram_dout;
    logic [2:0]        r_cnt;
    logic [2:0]        r_nbytes;
    logic              r_we;
    logic              r_ram_wr;
    logic              r_if_done;
    logic              r_mem_done;

    logic              w_idle_ok;
    logic              w_pick_mem;
    logic              w_grant_mem;
    logic              w_grant_if;
    logic              w_last_beat;
    logic [2:0]        w_cnt_inc;
    logic [1:0]        w_lane;
    logic [2:0]        w_mem_nbytes;
    logic [31:0]       w_buf_final;

`ifdef MEM_ARB_RR_EN
    logic              r_last_mem;
    // On contention the requester not served last wins.
    assign w_pick_mem = mem_req && (!if_req || !r_last_mem);
`else
    assign w_pick_mem = mem_req;
`endif

    // A done pulse blocks granting, which guarantees one IDLE cycle between accesses.
    assign w_idle_ok    = (r_state == ST_IDLE) && !r_if_done && !r_mem_done;
    assign w_grant_mem  = w_idle_ok && w_pick_mem;
    assign w_grant_if   = w_idle_ok && if_req && !w_pick_mem;
    assign w_mem_nbytes = (mem_len == 3'd1) ? 3'd1 : ((mem_len == 3'd2) ? 3'd2 : 3'd4);
    assign w_cnt_inc    = r_cnt + 3'd1;
    assign w_lane       = 2'(r_cnt - 3'd1);
    // Reads need one extra cycle for the RAM latency on the final byte.
    assign w_last_beat  = r_we ? (r_cnt == r_nbytes - 3'd1) : (r_cnt == r_nbytes);

    always_comb begin
        w_buf_final = r_buf;
        w_buf_final[{w_lane, 3'b000} +: 8] = ram_din;
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_grant_mem)
                    w_state_next = ST_BUSY_MEM;
                else if (w_grant_if)
                    w_state_next = ST_BUSY_IF;
            end
            ST_BUSY_IF, ST_BUSY_MEM: begin
                if (w_last_beat)
                    w_state_next = ST_IDLE;
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst)
            r_state <= ST_IDLE;
        else
            r_state <= w_state_next;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_addr      <= '0;
            r_ram_a     <= '0;
            r_wdata     <= '0;
            r_buf       <= '0;
            r_if_data   <= '0;
            r_mem_rdata <= '0;
            r_ram_dout  <= '0;
            r_cnt       <= '0;
            r_nbytes    <= '0;
            r_we        <= 1'b0;
            r_ram_wr    <= 1'b0;
            r_if_done   <= 1'b0;
            r_mem_done  <= 1'b0;
`ifdef MEM_ARB_RR_EN
            r_last_mem  <= 1'b0;
`endif
        end else begin
            r_if_done  <= 1'b0;
            r_mem_done <= 1'b0;
            if (w_grant_mem || w_grant_if) begin
                r_addr     <= w_grant_mem ? mem_addr : if_addr;
                r_ram_a    <= w_grant_mem ? mem_addr : if_addr;
                r_we       <= w_grant_mem && mem_we;
                r_ram_wr   <= w_grant_mem && mem_we;
                r_wdata    <= mem_wdata;
                r_ram_dout <= mem_wdata[7:0];
                r_cnt      <= '0;
                r_buf      <= '0;
                r_nbytes   <= w_grant_mem ? w_mem_nbytes : 3'd4;
`ifdef MEM_ARB_RR_EN
                r_last_mem <= w_grant_mem;
`endif
            end else if (r_state != ST_IDLE) begin
                if (!r_we && r_cnt != 3'd0)
                    r_buf[{w_lane, 3'b000} +: 8] <= ram_din;
                if (w_last_beat) begin
                    r_ram_wr <= 1'b0;
                    if (r_state == ST_BUSY_MEM) begin
                        r_mem_done <= 1'b1;
                        if (!r_we)
                            r_mem_rdata <= w_buf_final;
                    end else begin
                        r_if_done <= 1'b1;
                        r_if_data <= w_buf_final;
                    end
                end else begin
                    r_cnt <= w_cnt_inc;
                    // Address stays on the last byte while a read waits for its data.
                    if (w_cnt_inc < r_nbytes) begin
                        r_ram_a    <= r_addr + ADDR_W'(w_cnt_inc);
                        r_ram_dout <= r_wdata[{w_cnt_inc[1:0], 3'b000} +: 8];
                    end
                end
            end
        end
    end

    assign if_data      = r_if_data;
    assign if_done      = r_if_done;
    assign mem_rdata    = r_mem_rdata;
    assign mem_done     = r_mem_done;
    assign ram_a        = r_ram_a;
    assign ram_dout     = r_ram_dout;
    assign ram_wr       = r_ram_wr;
    assign stallreq_if  = if_req && !r_if_done;
    assign stallreq_mem = mem_req && !r_mem_done;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter with a 1 KiB byte RAM model (1-cycle read latency).
// Expectations for the contention test depend on MEM_ARB_RR_EN.
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        if_req = 1'b0;
    logic [31:0] if_addr = '0;
    logic [31:0] if_data;
    logic        if_done;
    logic        mem_req = 1'b0;
    logic        mem_we = 1'b0;
    logic [2:0]  mem_len = '0;
    logic [31:0] mem_addr = '0;
    logic [31:0] mem_wdata = '0;
    logic [31:0] mem_rdata;
    logic        mem_done;
    logic [31:0] ram_a;
    logic [7:0]  ram_dout;
    logic        ram_wr;
    logic [7:0]  ram_din = '0;
    logic        stallreq_if;
    logic        stallreq_mem;

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0]  ram_mem [0:1023];
    logic        pre_we = 1'b0;
    logic [9:0]  pre_a = '0;
    logic [7:0]  pre_d = '0;

    logic [31:0] tr_a    [0:31];
    logic        tr_wr   [0:31];
    logic [7:0]  tr_do   [0:31];
    logic        tr_sif  [0:31];
    logic        tr_smem [0:31];

    int k;
    bit rr_mode;

    mem_arbiter #(.ADDR_W(32)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_data(if_data), .if_done(if_done),
        .mem_req(mem_req), .mem_we(mem_we), .mem_len(mem_len), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_done(mem_done),
        .ram_a(ram_a), .ram_dout(ram_dout), .ram_wr(ram_wr), .ram_din(ram_din),
        .stallreq_if(stallreq_if), .stallreq_mem(stallreq_mem)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (pre_we)
            ram_mem[pre_a] <= pre_d;
        else if (ram_wr)
            ram_mem[ram_a[9:0]] <= ram_dout;
        ram_din <= ram_mem[ram_a[9:0]];
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic preload(input logic [9:0] a, input logic [7:0] d);
        @(negedge clk);
        pre_a  = a;
        pre_d  = d;
        pre_we = 1'b1;
        @(negedge clk);
        pre_we = 1'b0;
    endtask

    // Samples one cycle per negedge; c=0 is the first cycle after the request edge.
    task automatic run_until(input bit want_mem, output int kk);
        kk = -1;
        for (int c = 0; c < 32; c++) begin
            @(negedge clk);
            tr_a[c]    = ram_a;
            tr_wr[c]   = ram_wr;
            tr_do[c]   = ram_dout;
            tr_sif[c]  = stallreq_if;
            tr_smem[c] = stallreq_mem;
            if (want_mem ? mem_done : if_done) begin
                kk = c;
                break;
            end
        end
    endtask

    initial begin
`ifdef MEM_ARB_RR_EN
        rr_mode = 1'b1;
`else
        rr_mode = 1'b0;
`endif
        // Preload RAM while the DUT is held in reset
        preload(10'h100, 8'h11); preload(10'h101, 8'h22);
        preload(10'h102, 8'h33); preload(10'h103, 8'h44);
        preload(10'h104, 8'h55); preload(10'h105, 8'h66);
        preload(10'h106, 8'h77); preload(10'h107, 8'h88);
        preload(10'h2F0, 8'h80); preload(10'h2F1, 8'h7F);
        preload(10'h202, 8'h5A);
        @(negedge clk);
        check("rst_if_data", if_data, 32'h0);
        check("rst_mem_rdata", mem_rdata, 32'h0);
        check("rst_ram_a", ram_a, 32'h0);
        check("rst_ram_wr", {31'b0, ram_wr}, 32'h0);
        check("rst_dones", {30'b0, if_done, mem_done}, 32'h0);
        rst = 1'b0;
        @(negedge clk);
        $display("step reset: done");

        // IF fetch of 4 bytes
        if_addr = 32'h100; if_req = 1'b1;
        run_until(1'b0, k);
        check("fetch_done_cycle", k, 5);
        check("fetch_data", if_data, 32'h44332211);
        check("fetch_addr_c0", tr_a[0], 32'h100);
        check("fetch_addr_c3", tr_a[3], 32'h103);
        check("fetch_stall_c4", {31'b0, tr_sif[4]}, 32'h1);
        check("fetch_stall_done", {31'b0, tr_sif[5]}, 32'h0);
        if_req = 1'b0;
        $display("step fetch 0x100: k=%0d data=0x%08h", k, if_data);

        // Contention after an IF grant: MEM wins in both modes
        @(negedge clk);
        if_addr = 32'h104; if_req = 1'b1;
        mem_addr = 32'h2F0; mem_we = 1'b0; mem_len = 3'd2; mem_req = 1'b1;
        run_until(1'b1, k);
        check("cont1_mem_done_cycle", k, 3);
        check("cont1_mem_addr_c0", tr_a[0], 32'h2F0);
        check("cont1_mem_rdata", mem_rdata, 32'h00007F80);
        check("cont1_if_stalled", {31'b0, tr_sif[2]}, 32'h1);
        mem_req = 1'b0;
        run_until(1'b0, k);
        check("cont1_if_done_cycle", k, 6);
        check("cont1_idle_hold_a", tr_a[0], 32'h2F1);
        check("cont1_if_addr_c0", tr_a[1], 32'h104);
        check("cont1_if_data", if_data, 32'h88776655);
        if_req = 1'b0;
        $display("step contention 1: k=%0d if_data=0x%08h", k, if_data);

        // Store 2 bytes
        @(negedge clk);
        mem_addr = 32'h200; mem_we = 1'b1; mem_len = 3'd2; mem_wdata = 32'hAABBCCDD; mem_req = 1'b1;
        run_until(1'b1, k);
        check("st2_done_cycle", k, 2);
        check("st2_c0", {tr_wr[0], 15'b0, tr_a[0][7:0], tr_do[0]}, {1'b1, 15'b0, 8'h00, 8'hDD});
        check("st2_c1", {tr_wr[1], 15'b0, tr_a[1][7:0], tr_do[1]}, {1'b1, 15'b0, 8'h01, 8'hCC});
        check("st2_c2_nowr", {31'b0, tr_wr[2]}, 32'h0);
        check("st2_stall_c0", {31'b0, tr_smem[0]}, 32'h1);
        check("st2_stall_done", {31'b0, tr_smem[2]}, 32'h0);
        mem_req = 1'b0;
        @(negedge clk);
        check("st2_ram_200", {24'b0, ram_mem[10'h200]}, 32'hDD);
        check("st2_ram_202_untouched", {24'b0, ram_mem[10'h202]}, 32'h5A);
        $display("step store len2 0x200: k=%0d", k);

        // Load 1 byte
        mem_addr = 32'h2F0; mem_we = 1'b0; mem_len = 3'd1; mem_req = 1'b1;
        run_until(1'b1, k);
        check("ld1_done_cycle", k, 2);
        check("ld1_rdata", mem_rdata, 32'h00000080);
        check("ld1_if_data_held", if_data, 32'h88776655);
        mem_req = 1'b0;
        $display("step load len1 0x2F0: k=%0d rdata=0x%08h", k, mem_rdata);

        // mem_len=0 load behaves as 4 bytes
        @(negedge clk);
        mem_addr = 32'h100; mem_we = 1'b0; mem_len = 3'd0; mem_req = 1'b1;
        run_until(1'b1, k);
        check("ld0_done_cycle", k, 5);
        check("ld0_rdata", mem_rdata, 32'h44332211);
        mem_req = 1'b0;
        $display("step load len0 0x100: k=%0d rdata=0x%08h", k, mem_rdata);

        // mem_len=7 store behaves as 4 bytes
        @(negedge clk);
        mem_addr = 32'h210; mem_we = 1'b1; mem_len = 3'd7; mem_wdata = 32'h01020304; mem_req = 1'b1;
        run_until(1'b1, k);
        check("st7_done_cycle", k, 4);
        check("st7_c3", {tr_wr[3], 15'b0, tr_a[3][7:0], tr_do[3]}, {1'b1, 15'b0, 8'h13, 8'h01});
        check("st7_c4_nowr", {31'b0, tr_wr[4]}, 32'h0);
        mem_req = 1'b0;
        @(negedge clk);
        check("st7_ram_210", {24'b0, ram_mem[10'h210]}, 32'h04);
        check("st7_ram_213", {24'b0, ram_mem[10'h213]}, 32'h01);
        $display("step store len7 0x210: k=%0d", k);

        // Contention after a MEM grant: round robin favours IF
        if_addr = 32'h100; if_req = 1'b1;
        mem_addr = 32'h2F0; mem_we = 1'b0; mem_len = 3'd1; mem_req = 1'b1;
        if (rr_mode) begin
            run_until(1'b0, k);
            check("cont2_rr_if_done_cycle", k, 5);
            check("cont2_rr_if_addr_c0", tr_a[0], 32'h100);
            check("cont2_rr_if_data", if_data, 32'h44332211);
            if_req = 1'b0;
            run_until(1'b1, k);
            check("cont2_rr_mem_done_cycle", k, 3);
            check("cont2_rr_mem_rdata", mem_rdata, 32'h00000080);
            mem_req = 1'b0;
        end else begin
            run_until(1'b1, k);
            check("cont2_fp_mem_done_cycle", k, 2);
            check("cont2_fp_mem_addr_c0", tr_a[0], 32'h2F0);
            check("cont2_fp_mem_rdata", mem_rdata, 32'h00000080);
            mem_req = 1'b0;
            run_until(1'b0, k);
            check("cont2_fp_if_done_cycle", k, 6);
            check("cont2_fp_if_data", if_data, 32'h44332211);
            if_req = 1'b0;
        end
        $display("step contention 2 (rr=%0d): k=%0d", rr_mode, k);

        // Reset during cycle 1 of a 4-byte store
        @(negedge clk);
        mem_addr = 32'h220; mem_we = 1'b1; mem_len = 3'd4; mem_wdata = 32'hCAFEBABE; mem_req = 1'b1;
        @(negedge clk);
        check("rstmid_c0_wr", {31'b0, ram_wr}, 32'h1);
        @(negedge clk);
        rst = 1'b1; mem_req = 1'b0;
        @(negedge clk);
        check("rstmid_wr", {31'b0, ram_wr}, 32'h0);
        check("rstmid_ram_a", ram_a, 32'h0);
        check("rstmid_done", {30'b0, mem_done, if_done}, 32'h0);
        rst = 1'b0;
        @(negedge clk);
        check("rstmid_post_done", {30'b0, mem_done, ram_wr}, 32'h0);
        mem_addr = 32'h2F0; mem_we = 1'b0; mem_len = 3'd2; mem_req = 1'b1;
        run_until(1'b1, k);
        check("rstmid_ld_done_cycle", k, 3);
        check("rstmid_ld_rdata", mem_rdata, 32'h00007F80);
        mem_req = 1'b0;
        $display("step reset mid-store then load: k=%0d rdata=0x%08h", k, mem_rdata);

        @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
